// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer: fetch (T0-T2) followed by execute/writeback
// for register-format ALU instructions, driving datapath bus selects and load enables.
module control_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR_Data,
  input  logic        mem_ready,
  input  logic        Stop,
  output logic        PC_out,
  output logic        Zlow_out,
  output logic        Zhigh_out,
  output logic        MDR_out,
  output logic        R_out,
  output logic        PC_in,
  output logic        IR_in,
  output logic        MAR_in,
  output logic        MDR_in,
  output logic        Y_in,
  output logic        Z_in,
  output logic        R_in,
  output logic        LO_in,
  output logic        HI_in,
  output logic        Read,
  output logic        IncPC,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic [4:0]  alu_instruction,
  output logic        Run
);

  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    RST, T0, T1, T2, T3, T4, T5, T6, HALT
  } state_t;

  state_t     state, state_next;
  logic [4:0] opcode;
  logic       is_muldiv;
  logic       is_unary;
  state_t     end_state;

  assign opcode    = IR_Data[31:27];
  assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
  assign end_state = Stop ? HALT : T0;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= RST;
    else      state <= state_next;
  end

  // IR_Data is only meaningful from T3 onward, after IR has loaded at the end of T2.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      RST:  state_next = T0;
      T0:   state_next = T1;
      T1:   state_next = mem_ready ? T2 : T1;
      T2:   state_next = T3;
      T3: begin
        if      (opcode == OP_NOP)  state_next = end_state;
        else if (opcode == OP_HALT) state_next = HALT;
        else                        state_next = T4;
      end
      T4:   state_next = T5;
      T5:   state_next = is_muldiv ? T6 : end_state;
      T6:   state_next = end_state;
      HALT: state_next = HALT;
      default: state_next = RST;
    endcase
  end

  always_comb begin
    PC_out          = 1'b0;
    Zlow_out        = 1'b0;
    Zhigh_out       = 1'b0;
    MDR_out         = 1'b0;
    R_out           = 1'b0;
    PC_in           = 1'b0;
    IR_in           = 1'b0;
    MAR_in          = 1'b0;
    MDR_in          = 1'b0;
    Y_in            = 1'b0;
    Z_in            = 1'b0;
    R_in            = 1'b0;
    LO_in           = 1'b0;
    HI_in           = 1'b0;
    Read            = 1'b0;
    IncPC           = 1'b0;
    Gra             = 1'b0;
    Grb             = 1'b0;
    Grc             = 1'b0;
    alu_instruction = 5'd0;
    Run             = (state != RST) && (state != HALT);
    unique case (state)
      T0: begin
        PC_out = 1'b1;
        MAR_in = 1'b1;
        IncPC  = 1'b1;
        Z_in   = 1'b1;
      end
      T1: begin
        // A stalled T1 reloads PC from the same Z value, so holding here is harmless.
        Zlow_out = 1'b1;
        PC_in    = 1'b1;
        Read     = 1'b1;
        MDR_in   = 1'b1;
      end
      T2: begin
        MDR_out = 1'b1;
        IR_in   = 1'b1;
      end
      T3: begin
        Grb   = 1'b1;
        R_out = 1'b1;
        Y_in  = 1'b1;
      end
      T4: begin
        R_out           = 1'b1;
        Z_in            = 1'b1;
        Grb             = is_unary;
        Grc             = !is_unary;
        alu_instruction = opcode;
      end
      T5: begin
        Zlow_out = 1'b1;
        LO_in    = is_muldiv;
        Gra      = !is_muldiv;
        R_in     = !is_muldiv;
      end
      T6: begin
        Zhigh_out = 1'b1;
        HI_in     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer: the driver pushes the expected
// per-cycle strobe pattern of each instruction, a negedge monitor pops and compares.
module tb_control_sequencer;

  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef struct packed {
    logic pc_out, zlow_out, zhigh_out, mdr_out, r_out;
    logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, r_in;
    logic lo_in, hi_in, read, inc_pc;
    logic gra, grb, grc, run;
    logic [4:0] alu;
  } strobes_t;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] IR_Data = '0;
  logic        mem_ready = 1'b0;
  logic        Stop = 1'b0;
  logic PC_out, Zlow_out, Zhigh_out, MDR_out, R_out;
  logic PC_in, IR_in, MAR_in, MDR_in, Y_in, Z_in, R_in;
  logic LO_in, HI_in, Read, IncPC, Gra, Grb, Grc, Run;
  logic [4:0] alu_instruction;

  control_sequencer dut (
    .clk(clk), .clr(clr), .IR_Data(IR_Data), .mem_ready(mem_ready), .Stop(Stop),
    .PC_out(PC_out), .Zlow_out(Zlow_out), .Zhigh_out(Zhigh_out), .MDR_out(MDR_out),
    .R_out(R_out), .PC_in(PC_in), .IR_in(IR_in), .MAR_in(MAR_in), .MDR_in(MDR_in),
    .Y_in(Y_in), .Z_in(Z_in), .R_in(R_in), .LO_in(LO_in), .HI_in(HI_in),
    .Read(Read), .IncPC(IncPC), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .alu_instruction(alu_instruction), .Run(Run)
  );

  always #5 clk = ~clk;

  int       n_checks = 0;
  int       n_fail   = 0;
  strobes_t exp_q[$];
  string    tag_q[$];
  strobes_t plan_q[$];
  string    plan_tag_q[$];
  strobes_t actual;

  always_comb begin
    actual = {PC_out, Zlow_out, Zhigh_out, MDR_out, R_out,
              PC_in, IR_in, MAR_in, MDR_in, Y_in, Z_in, R_in,
              LO_in, HI_in, Read, IncPC, Gra, Grb, Grc, Run, alu_instruction};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare every sampled cycle that has an expectation, plus the bus-driver invariant.
  always @(negedge clk) begin
    int drivers;
    drivers = int'(PC_out) + int'(Zlow_out) + int'(Zhigh_out) + int'(MDR_out) + int'(R_out);
    check("bus_drivers", drivers, Run ? 1 : 0);
    if (exp_q.size() > 0) begin
      strobes_t e;
      string    t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, actual, e);
    end
  end

  task automatic add_plan(input strobes_t v, input string t);
    plan_q.push_back(v);
    plan_tag_q.push_back(t);
  endtask

  // Reference model: the strobe list of a whole instruction from its opcode and stall count.
  task automatic build_plan(input logic [31:0] ir, input int stalls);
    strobes_t   s;
    logic [4:0] op;
    op = ir[31:27];
    plan_q.delete();
    plan_tag_q.delete();
    s = '0; s.run = 1; s.pc_out = 1; s.mar_in = 1; s.inc_pc = 1; s.z_in = 1;
    add_plan(s, "T0");
    for (int i = 0; i <= stalls; i++) begin
      s = '0; s.run = 1; s.zlow_out = 1; s.pc_in = 1; s.read = 1; s.mdr_in = 1;
      add_plan(s, "T1");
    end
    s = '0; s.run = 1; s.mdr_out = 1; s.ir_in = 1;
    add_plan(s, "T2");
    s = '0; s.run = 1; s.grb = 1; s.r_out = 1; s.y_in = 1;
    add_plan(s, "T3");
    if (op == OP_NOP || op == OP_HALT) return;
    s = '0; s.run = 1; s.r_out = 1; s.z_in = 1; s.alu = op;
    if (op == OP_NEG || op == OP_NOT) s.grb = 1;
    else                              s.grc = 1;
    add_plan(s, "T4");
    s = '0; s.run = 1; s.zlow_out = 1;
    if (op == OP_MUL || op == OP_DIV) s.lo_in = 1;
    else begin
      s.gra = 1; s.r_in = 1;
    end
    add_plan(s, "T5");
    if (op == OP_MUL || op == OP_DIV) begin
      s = '0; s.run = 1; s.zhigh_out = 1; s.hi_in = 1;
      add_plan(s, "T6");
    end
  endtask

  // One clock of stimulus: IR only becomes valid from T3, mem_ready matters only in T1,
  // Stop only on the instruction's final edge; everything else is random noise.
  task automatic drive_cycle(input logic [31:0] ir, input int stalls, input int c,
                             input bit last, input bit stop);
    logic [31:0] noise;
    noise     = $urandom;
    IR_Data   = (c >= 3 + stalls) ? ir : noise;
    if (c >= 1 && c <= 1 + stalls) mem_ready = (c == 1 + stalls);
    else                           mem_ready = 1'($urandom_range(0, 1));
    Stop      = last ? stop : 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  task automatic push_plan(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(plan_q[i]);
      tag_q.push_back(plan_tag_q[i]);
    end
  endtask

  task automatic push_idle(input int n, input string t);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('0);
      tag_q.push_back(t);
    end
  endtask

  // Release reset just after an edge: one RST cycle (all zero), then T0.
  task automatic apply_reset();
    clr = 1'b0;
    @(posedge clk);
    #1;
    check("reset_outputs", actual, 32'd0);
    clr = 1'b1;
    push_idle(1, "RST");
    @(posedge clk);
    #1;
  endtask

  // Called with the DUT in T0; returns with the DUT in T0 again (or reset back to it).
  task automatic run_instr(input logic [31:0] ir, input int stalls, input bit stop);
    bit halts;
    int n;
    build_plan(ir, stalls);
    n = plan_q.size();
    halts = stop || (ir[31:27] == OP_HALT);
    push_plan(n);
    for (int c = 0; c < n; c++) drive_cycle(ir, stalls, c, c == n - 1, stop);
    if (halts) begin
      push_idle(3, "HALT");
      repeat (3) drive_cycle(ir, stalls, 0, 1'b0, 1'b0);
      apply_reset();
    end
  endtask

  // Pull clr low in the middle of T4 and confirm the outputs drop without waiting for an edge.
  task automatic run_abort(input logic [31:0] ir);
    build_plan(ir, 0);
    push_plan(5);
    for (int c = 0; c < 4; c++) drive_cycle(ir, 0, c, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    clr = 1'b0;
    #1;
    check("async_clear", actual, 32'd0);
    apply_reset();
  endtask

  function automatic logic [31:0] make_ir(input logic [4:0] op);
    logic [31:0] r;
    r = $urandom;
    return {op, r[26:0]};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    apply_reset();
    run_instr(32'h409A8000, 0, 1'b0);
    run_instr(32'h409A8000, 3, 1'b0);
    run_instr(make_ir(OP_MUL), 0, 1'b0);
    run_instr(make_ir(OP_NEG), 1, 1'b0);
    run_instr(make_ir(OP_NOP), 0, 1'b0);
    run_instr(32'h409A8000, 0, 1'b1);
    run_instr(make_ir(OP_HALT), 0, 1'b0);
    run_abort(32'h409A8000);
    for (int k = 0; k < 40; k++) begin
      int         sel;
      logic [4:0] op;
      sel = $urandom_range(0, 19);
      case (sel)
        0:       op = OP_MUL;
        1:       op = OP_DIV;
        2:       op = OP_NEG;
        3:       op = OP_NOT;
        4, 5:    op = OP_NOP;
        6:       op = OP_HALT;
        default: op = 5'($urandom_range(0, 14));
      endcase
      run_instr(make_ir(op), $urandom_range(0, 3), $urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
